reaction_game_ctrl: RTL

- Game controller for the dual seven-segment reaction-time game.
- Sequences START -> READY -> PLAY -> FINISH from one debounced push-button, using a random wait from a free-running LFSR.
- Counts the reaction time in BCD.
- Drives the tens/ones digit inputs of the display driver.
- Sits inside the Tiny Tapeout top beside the clock divider and the seven-segment mux.

---
 rtl/reaction_game_ctrl_if.sv | 24 ++
 rtl/reaction_game_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reaction_game_ctrl_if.sv
// Pin bundle between the reaction game controller and the board/display side.
// Latency: none, plain wires.
// Backpressure: none; button is a raw level, the display outputs are levels.
interface reaction_game_ctrl_if;
  logic       button;
  logic [3:0] tens;
  logic [3:0] ones;
  logic [1:0] state;
  logic       go;
  logic       foul;
  logic       timeout;

  // Controller side: samples the button and drives the display and status lines.
  modport master (
    input  button,
    output tens, ones, state, go, foul, timeout
  );

  // Board side: drives the button and observes the display and status lines.
  modport slave (
    output button,
    input  tens, ones, state, go, foul, timeout
  );
endinterface

// File: rtl/reaction_game_ctrl.sv
// Reaction game sequencer START -> READY -> PLAY -> FINISH with a BCD reaction score.
// Latency: press acts on the 3rd clk edge after button rises; outputs are registered.
// Backpressure: none; a held button gives one press. Macro REACTION_BEST_SCORE_EN adds a best score.
module reaction_game_ctrl #(
  parameter int unsigned PRESCALE  = 1000,
  parameter int unsigned MIN_WAIT  = 20,
  parameter logic [7:0]  WAIT_MASK = 8'h3F
) (
  input logic                  clk,
  input logic                  reset,
  reaction_game_ctrl_if.master game
);

  localparam int unsigned PW    = $clog2(PRESCALE);
  localparam int unsigned WW    = $clog2(MIN_WAIT + 256);
  localparam logic [7:0]  BLANK = 8'hFF;
  localparam logic [7:0]  TOP   = 8'h99;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_READY  = 2'd1,
    ST_PLAY   = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t          state_q, state_nxt;
  logic            btn_s1, btn_s2, btn_s3;
  logic            press;
  logic [7:0]      lfsr;
  logic [PW-1:0]   presc;
  logic            unit_tick;
  logic [WW-1:0]   wait_q, wait_nxt;
  logic [7:0]      score_q, score_nxt;
  logic [7:0]      disp_q, disp_nxt;
  logic            go_q, go_nxt;
  logic            foul_q, foul_nxt;
  logic            timeout_q, timeout_nxt;
`ifdef REACTION_BEST_SCORE_EN
  logic [7:0]      best_q, best_nxt;
`endif

  // Two-digit BCD increment; ones 9 rolls to 0 and carries into tens.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Two-flop synchronizer plus one delay flop for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_s3 <= 1'b0;
    end else begin
      btn_s1 <= game.button;
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
    end
  end

  assign press = btn_s2 & ~btn_s3;

  // Free-running Fibonacci LFSR (taps 8,6,5,4) used as the source of the random wait.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= 8'hA5;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign unit_tick = (presc == PW'(PRESCALE - 1));

  // Score-unit prescaler; restarts on every state change so the first tick lands PRESCALE cycles in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc <= '0;
    end else if ((state_nxt != state_q) || unit_tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Next-state and next-output decode; a press always outranks a coincident unit tick.
  always_comb begin
    state_nxt   = state_q;
    wait_nxt    = wait_q;
    score_nxt   = score_q;
    disp_nxt    = disp_q;
    foul_nxt    = foul_q;
    timeout_nxt = timeout_q;
`ifdef REACTION_BEST_SCORE_EN
    best_nxt    = best_q;
`endif
    case (state_q)
      ST_START: begin
        if (press) begin
          state_nxt   = ST_READY;
          wait_nxt    = WW'(MIN_WAIT) + WW'(lfsr & WAIT_MASK);
          disp_nxt    = BLANK;
          foul_nxt    = 1'b0;
          timeout_nxt = 1'b0;
        end
      end
      ST_READY: begin
        if (press) begin
          // False start: the player jumped before the go light.
          state_nxt = ST_FINISH;
          foul_nxt  = 1'b1;
          score_nxt = 8'h00;
          disp_nxt  = 8'h00;
        end else if (unit_tick) begin
          if (wait_q <= WW'(1)) begin
            state_nxt = ST_PLAY;
            score_nxt = 8'h00;
            disp_nxt  = 8'h00;
          end else begin
            wait_nxt = wait_q - WW'(1);
          end
        end
      end
      ST_PLAY: begin
        if (press) begin
          // Score freezes at its pre-tick value.
          state_nxt = ST_FINISH;
          disp_nxt  = score_q;
`ifdef REACTION_BEST_SCORE_EN
          if (score_q < best_q) begin
            best_nxt = score_q;
          end
`endif
        end else if (unit_tick) begin
          if (score_q == TOP) begin
            state_nxt   = ST_FINISH;
            timeout_nxt = 1'b1;
            disp_nxt    = TOP;
          end else begin
            score_nxt = bcd_inc(score_q);
            disp_nxt  = bcd_inc(score_q);
          end
        end
      end
      default: begin
        if (press) begin
          state_nxt = ST_START;
`ifdef REACTION_BEST_SCORE_EN
          disp_nxt  = best_q;
`else
          disp_nxt  = score_q;
`endif
        end
      end
    endcase
    go_nxt = (state_nxt == ST_PLAY);
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_START;
      wait_q    <= '0;
      score_q   <= 8'h00;
      disp_q    <= 8'h00;
      go_q      <= 1'b0;
      foul_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      wait_q    <= wait_nxt;
      score_q   <= score_nxt;
      disp_q    <= disp_nxt;
      go_q      <= go_nxt;
      foul_q    <= foul_nxt;
      timeout_q <= timeout_nxt;
    end
  end

`ifdef REACTION_BEST_SCORE_EN
  // Best (lowest) clean reaction score since reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_q <= TOP;
    end else begin
      best_q <= best_nxt;
    end
  end
`endif

  assign game.state   = state_q;
  assign game.tens    = disp_q[7:4];
  assign game.ones    = disp_q[3:0];
  assign game.go      = go_q;
  assign game.foul    = foul_q;
  assign game.timeout = timeout_q;

endmodule
